// File: rtl/ce_pulse_gen.sv
// ce_pulse_gen: start/stop button debouncer driving a run FSM and a DIV-cycle count-enable prescaler.
// Ports:
//   C1K    in  system clock, rising edge
//   RST    in  asynchronous active-low reset
//   BTN    in  raw, bouncing, asynchronous start/stop button (active-high)
//   CE     out one-cycle count-enable pulse every DIV cycles while running
//   RUN    out run status (1 = generating CE)
//   BTN_DB out debounced button level
module ce_pulse_gen #(
  parameter int DIV    = 1000,
  parameter int DB_CNT = 16
) (
  input  logic C1K,
  input  logic RST,
  input  logic BTN,
  output logic CE,
  output logic RUN,
  output logic BTN_DB
);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int CW = DB_CNT > 1 ? $clog2(DB_CNT) : 1;
  typedef enum logic {ST_STOP = 1'b0, ST_RUN = 1'b1} state_t;
  state_t state_q, state_d;
  logic s1_q, s2_q, db_q, db_d, ce_q, ce_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic diff, hit, press, stay;
  always_comb begin
    diff    = s2_q != db_q;
    hit     = diff && cnt_q == CW'(DB_CNT - 1);
    press   = hit && s2_q;
    cnt_d   = (diff && !hit) ? cnt_q + 1'b1 : '0;
    db_d    = hit ? s2_q : db_q;
    state_d = press ? (state_q == ST_STOP ? ST_RUN : ST_STOP) : state_q;
    // Prescaler only advances while running on both sides of the edge; entering or leaving clears it.
    stay    = state_q == ST_RUN && state_d == ST_RUN;
    pcnt_d  = (stay && pcnt_q != PW'(DIV - 1)) ? pcnt_q + 1'b1 : '0;
    ce_d    = stay && pcnt_q == PW'(DIV - 1);
  end
  always_ff @(posedge C1K or negedge RST)
    if (!RST) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      state_q <= ST_STOP;
      pcnt_q  <= '0;
      ce_q    <= 1'b0;
    end else begin
      s1_q    <= BTN;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      ce_q    <= ce_d;
    end
  assign CE     = ce_q;
  assign RUN    = state_q == ST_RUN;
  assign BTN_DB = db_q;
endmodule

// File: doc/ce_pulse_gen.md
CE_PULSE_GEN -- requirements
Module: ce_pulse_gen

Interface
REQ-001 Parameter DIV, default 1000, CE period in C1K cycles (legal range >= 1).
REQ-002 Parameter DB_CNT, default 16, consecutive stable cycles needed to accept a button level change (legal range >= 1).
REQ-003 C1K  input  1  system clock; all state changes on the rising edge.
REQ-004 RST  input  1  reset; asynchronous, active-low.
REQ-005 BTN  input  1  raw start/stop push button, active-high, asynchronous to C1K, may bounce.
REQ-006 CE  output  1  count-enable pulse for the downstream 4-bit counter's CE input; high for one cycle per period while running.
REQ-007 RUN  output  1  run status; 1 = generating CE pulses.
REQ-008 BTN_DB  output  1  debounced button level.

Function
REQ-009 BTN SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-010 The debounce counter SHALL count edges on which s2 differs from BTN_DB, and SHALL clear to 0 on any edge where s2 equals BTN_DB.
REQ-011 BTN_DB SHALL take the value of s2 on the edge where the counter already holds DB_CNT-1 and s2 still differs; the counter SHALL clear on that same edge.
REQ-012 A 0->1 change of BTN_DB SHALL toggle RUN on the same edge; a 1->0 change SHALL NOT affect RUN.
REQ-013 Press latency: BTN stable high from before edge 1 -> BTN_DB=1 and RUN toggles at edge 2+DB_CNT.
REQ-014 State machine: two states, STOP (RUN=0) and RUN (RUN=1); the only transitions are per REQ-012.
REQ-015 Prescaler PCNT width SHALL be clog2(DIV), minimum 1 bit.
REQ-016 In STOP, PCNT=0 and CE=0.
REQ-017 On the edge entering RUN, PCNT SHALL load 0 and CE SHALL be 0.
REQ-018 In RUN, each edge: if PCNT==DIV-1 then PCNT<=0 and CE<=1, else PCNT<=PCNT+1 and CE<=0.
REQ-019 Consequence of REQ-018: entering RUN at edge k -> CE high after edges k+DIV, k+2*DIV, ...; exact period DIV; no drift.
REQ-020 DIV=1 SHALL give CE=1 continuously from edge k+1 while in RUN.
REQ-021 CE SHALL be driven directly from a flop (glitch-free).
REQ-022 Stop and terminal count on the same edge: stop wins -> CE<=0, PCNT<=0.
REQ-023 On the edge leaving RUN, CE<=0 and PCNT<=0; no partial-period pulse is emitted later.

Reset
REQ-024 RST=0 SHALL immediately force s1=s2=0, debounce counter=0, BTN_DB=0, PCNT=0, CE=0, RUN=0 (STOP), independent of C1K.
REQ-025 After RST rises, a button still held high SHALL be treated as a new press: RUN=1 at edge 2+DB_CNT after release of reset.
REQ-026 Reset asserted mid-period SHALL discard the partial period; the first CE after restart follows REQ-019.

Verification (DIV=4, DB_CNT=3 unless stated)
REQ-027 Reset: RST=0 with BTN toggling and C1K running -> CE=0, RUN=0, BTN_DB=0 throughout.
REQ-028 Clean press: BTN held 1 from before edge 1 -> RUN=1 and BTN_DB=1 at edge 5; CE=1 only after edges 9, 13, 17, ...; CE=0 after all other edges.
REQ-029 Bounce rejection: BTN alternates 1/0 every cycle for 12 cycles, then 0 -> BTN_DB=0, RUN=0, CE=0 throughout.
REQ-030 Stop: while running, release BTN then press again -> release leaves RUN=1; the second press sets RUN=0 at press edge+5; no CE afterwards, including when the stop edge coincides with a terminal count (CE=0 at that edge).
REQ-031 DIV=1: press -> CE=1 on every edge after the RUN edge; stop -> CE=0 from the stop edge.
REQ-032 Reset mid-run: drop RST between pulses with BTN held 1 -> CE=0 and RUN=0 immediately; after RST rises, RUN=1 at edge 5 and the first CE at edge 9.
